// File: rtl/aes_in_loader.sv
// aes_in_loader: accepts one 128-bit block plus key over valid/ready and streams
// both MSB-byte-first into the AES engine. It then holds en_signal for a fixed
// run window and pulses blk_done when the block ends.
// Optional feature macro: AES_IN_KEY_REUSE_EN
//   defined   - remembers the last key and reports key_stored when it repeats.
//   undefined - no key register or comparator; every block reports key_changed.
module aes_in_loader #(
    parameter int unsigned RUN_CYCLES = 160,
    parameter int unsigned CNT_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    input  logic         in_enc_dec,
    output logic         en_signal,
    output logic         enc_dec,
    output logic         key_stored,
    output logic         key_changed,
    output logic [7:0]   user_data_in,
    output logic [7:0]   user_key_in,
    output logic         busy,
    output logic         blk_done
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] RunLast = CNT_W'(RUN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    // Remaining bytes still to be presented; the top byte is always next.
    logic [127:0]       data_sr_q, data_sr_d;
    logic [127:0]       key_sr_q, key_sr_d;

    logic               in_ready_q, in_ready_d;
    logic               en_signal_q, en_signal_d;
    logic               enc_dec_q, enc_dec_d;
    logic               key_stored_q, key_stored_d;
    logic               key_changed_q, key_changed_d;
    logic [7:0]         user_data_in_q, user_data_in_d;
    logic [7:0]         user_key_in_q, user_key_in_d;
    logic               busy_q, busy_d;
    logic               blk_done_q, blk_done_d;

    logic               key_match;

`ifdef AES_IN_KEY_REUSE_EN
    logic [127:0]       last_key_q, last_key_d;
    logic               key_valid_q, key_valid_d;

    assign key_match = key_valid_q && (in_key == last_key_q);

    // Key history: capture the offered key on every accept.
    always_comb begin
        last_key_d  = last_key_q;
        key_valid_d = key_valid_q;
        if (state_q == StIdle && in_valid) begin
            last_key_d  = in_key;
            key_valid_d = 1'b1;
        end
    end

    // Key history registers; reset forgets the engine's key.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_key_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            last_key_q  <= last_key_d;
            key_valid_q <= key_valid_d;
        end
    end
`else
    assign key_match = 1'b0;
`endif

    // Next-state and next-output logic; all outputs are registered.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        run_cnt_d      = run_cnt_q;
        data_sr_d      = data_sr_q;
        key_sr_d       = key_sr_q;
        in_ready_d     = in_ready_q;
        en_signal_d    = en_signal_q;
        enc_dec_d      = enc_dec_q;
        key_stored_d   = key_stored_q;
        key_changed_d  = key_changed_q;
        user_data_in_d = user_data_in_q;
        user_key_in_d  = user_key_in_q;
        busy_d         = busy_q;
        blk_done_d     = blk_done_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d        = StLoad;
                    byte_cnt_d     = 4'd0;
                    // Byte 0 goes out in the first LOAD cycle; keep the rest queued.
                    user_data_in_d = in_data[127:120];
                    user_key_in_d  = in_key[127:120];
                    data_sr_d      = {in_data[119:0], 8'h00};
                    key_sr_d       = {in_key[119:0], 8'h00};
                    in_ready_d     = 1'b0;
                    en_signal_d    = 1'b1;
                    busy_d         = 1'b1;
                    enc_dec_d      = in_enc_dec;
                    key_stored_d   = key_match;
                    key_changed_d  = !key_match;
                end
            end
            StLoad: begin
                if (byte_cnt_q == 4'd15) begin
                    state_d        = StRun;
                    run_cnt_d      = '0;
                    user_data_in_d = 8'h00;
                    user_key_in_d  = 8'h00;
                end else begin
                    byte_cnt_d     = byte_cnt_q + 4'd1;
                    user_data_in_d = data_sr_q[127:120];
                    user_key_in_d  = key_sr_q[127:120];
                    data_sr_d      = {data_sr_q[119:0], 8'h00};
                    key_sr_d       = {key_sr_q[119:0], 8'h00};
                end
            end
            StRun: begin
                if (run_cnt_q == RunLast) begin
                    state_d     = StDone;
                    en_signal_d = 1'b0;
                    blk_done_d  = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d       = StIdle;
                blk_done_d    = 1'b0;
                busy_d        = 1'b0;
                in_ready_d    = 1'b1;
                key_stored_d  = 1'b0;
                key_changed_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            byte_cnt_q     <= 4'd0;
            run_cnt_q      <= '0;
            data_sr_q      <= '0;
            key_sr_q       <= '0;
            in_ready_q     <= 1'b1;
            en_signal_q    <= 1'b0;
            enc_dec_q      <= 1'b0;
            key_stored_q   <= 1'b0;
            key_changed_q  <= 1'b0;
            user_data_in_q <= 8'h00;
            user_key_in_q  <= 8'h00;
            busy_q         <= 1'b0;
            blk_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            run_cnt_q      <= run_cnt_d;
            data_sr_q      <= data_sr_d;
            key_sr_q       <= key_sr_d;
            in_ready_q     <= in_ready_d;
            en_signal_q    <= en_signal_d;
            enc_dec_q      <= enc_dec_d;
            key_stored_q   <= key_stored_d;
            key_changed_q  <= key_changed_d;
            user_data_in_q <= user_data_in_d;
            user_key_in_q  <= user_key_in_d;
            busy_q         <= busy_d;
            blk_done_q     <= blk_done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign en_signal    = en_signal_q;
    assign enc_dec      = enc_dec_q;
    assign key_stored   = key_stored_q;
    assign key_changed  = key_changed_q;
    assign user_data_in = user_data_in_q;
    assign user_key_in  = user_key_in_q;
    assign busy         = busy_q;
    assign blk_done     = blk_done_q;

endmodule
